funprof_ctrl: RTL and testbench

- Sequencing controller for the function profiler.
- Consumes the single-cycle call/ret strobes produced by the instruction decoder, together with the call target address.
- Maintains a hardware call stack of {function address, entry timestamp} and emits one profile record per completed function through a valid/ready interface to the record sink (trace buffer / bus slave).
- Owns profiler run/flush sequencing and the overflow, underflow and drop bookkeeping.

---
 rtl/funprof_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_funprof_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/funprof_ctrl.sv
// Function-profiler sequencer: call stack of {addr, entry ts}, one record per completed function.
// Optional FUNPROF_EXCL_EN: stack also tracks child time so records carry exclusive cycles.
module funprof_ctrl #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TS_W   = 32,
  parameter int unsigned DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   call,
  input  logic                   ret,
  input  logic [0:31]            call_target,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [0:31]            rec_addr,
  output logic [0:TS_W-1]        rec_cycles,
  output logic [0:$clog2(DEPTH)] rec_depth,
  output logic                   rec_trunc,
  output logic                   busy,
  output logic                   ovf,
  output logic                   unf,
  output logic [0:DROP_W-1]      drop_cnt
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned SpW  = IdxW + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [SpW-1:0]    sp_q, sp_d, sp_mid;
  logic [TS_W-1:0]   shadow_q, shadow_d, shadow_mid;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              rv_q, rv_d, rtrunc_q, rtrunc_d;
  logic [31:0]       raddr_q, raddr_d;
  logic [TS_W-1:0]   rcyc_q, rcyc_d;
  logic [SpW-1:0]    rdepth_q, rdepth_d;

  logic [31:0]       stk_addr_q [DEPTH];
  logic [TS_W-1:0]   stk_ts_q   [DEPTH];

  logic              hold_free, do_pop, do_push;
  logic [IdxW-1:0]   top_idx, push_idx;
  logic [TS_W-1:0]   incl, rec_cyc;

  assign hold_free = ~rv_q | rec_ready;
  assign top_idx   = IdxW'(sp_q - SpW'(1));
  assign push_idx  = IdxW'(sp_mid);
  // Unsigned subtraction absorbs a single wrap of the timestamp.
  assign incl      = ts_q - stk_ts_q[top_idx];

`ifdef FUNPROF_EXCL_EN
  logic [TS_W-1:0] stk_child_q [DEPTH];
  logic            add_child;

  assign add_child = do_pop & (sp_q > SpW'(1));
  assign rec_cyc   = incl - stk_child_q[top_idx];

  always_ff @(posedge clk) begin
    if (add_child) stk_child_q[top_idx - IdxW'(1)] <= stk_child_q[top_idx - IdxW'(1)] + incl;
    if (do_push)   stk_child_q[push_idx] <= '0;
  end
`else
  assign rec_cyc = incl;
`endif

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    shadow_d   = shadow_q;
    ts_d       = ts_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    drop_d     = drop_q;
    do_pop     = 1'b0;
    do_push    = 1'b0;
    sp_mid     = sp_q;
    shadow_mid = shadow_q;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d  = StRun;
          ts_d     = '0;
          sp_d     = '0;
          shadow_d = '0;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          drop_d   = '0;
        end
      end
      StRun: begin
        ts_d = ts_q + TS_W'(1);
        // Ret is resolved before call so a same-cycle pair replaces the top entry.
        if (ret) begin
          if (shadow_q != '0)  shadow_mid = shadow_q - TS_W'(1);
          else if (sp_q != '0) do_pop = 1'b1;
          else                 unf_d = 1'b1;
        end
        sp_mid   = do_pop ? sp_q - SpW'(1) : sp_q;
        sp_d     = sp_mid;
        shadow_d = shadow_mid;
        if (call) begin
          if (sp_mid < SpW'(DEPTH)) begin
            do_push = 1'b1;
            sp_d    = sp_mid + SpW'(1);
          end else begin
            ovf_d = 1'b1;
            if (shadow_mid != '1) shadow_d = shadow_mid + TS_W'(1);
          end
        end
        if (do_pop && !hold_free && drop_q != '1) drop_d = drop_q + DROP_W'(1);
        if (!enable) begin
          state_d  = StFlush;
          shadow_d = '0;
        end
      end
      StFlush: begin
        ts_d = ts_q + TS_W'(1);
        if (sp_q != '0) begin
          if (hold_free) begin
            do_pop = 1'b1;
            sp_d   = sp_q - SpW'(1);
          end
        end else if (hold_free) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rv_d     = rv_q & ~rec_ready;
    raddr_d  = raddr_q;
    rcyc_d   = rcyc_q;
    rdepth_d = rdepth_q;
    rtrunc_d = rtrunc_q;
    if (do_pop && hold_free) begin
      rv_d     = 1'b1;
      raddr_d  = stk_addr_q[top_idx];
      rcyc_d   = rec_cyc;
      rdepth_d = sp_q;
      rtrunc_d = (state_q == StFlush);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      stk_addr_q[push_idx] <= call_target;
      stk_ts_q[push_idx]   <= ts_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sp_q     <= '0;
      shadow_q <= '0;
      ts_q     <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      drop_q   <= '0;
      rv_q     <= 1'b0;
      raddr_q  <= '0;
      rcyc_q   <= '0;
      rdepth_q <= '0;
      rtrunc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sp_q     <= sp_d;
      shadow_q <= shadow_d;
      ts_q     <= ts_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      drop_q   <= drop_d;
      rv_q     <= rv_d;
      raddr_q  <= raddr_d;
      rcyc_q   <= rcyc_d;
      rdepth_q <= rdepth_d;
      rtrunc_q <= rtrunc_d;
    end
  end

  assign rec_valid  = rv_q;
  assign rec_addr   = raddr_q;
  assign rec_cycles = rcyc_q;
  assign rec_depth  = rdepth_q;
  assign rec_trunc  = rtrunc_q;
  assign busy       = (state_q != StIdle);
  assign ovf        = ovf_q;
  assign unf        = unf_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_funprof_ctrl.sv
// Bench for funprof_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_funprof_ctrl;

  localparam int D  = 4;
  localparam int TW = 8;
  localparam int DW = 4;
`ifdef FUNPROF_EXCL_EN
  localparam bit Excl = 1'b1;
`else
  localparam bit Excl = 1'b0;
`endif

  logic          clk, rst_n, enable, call, ret, rec_ready;
  logic [31:0]   call_target;
  logic          rec_valid, rec_trunc, busy, ovf, unf;
  logic [31:0]   rec_addr;
  logic [TW-1:0] rec_cycles;
  logic [2:0]    rec_depth;
  logic [DW-1:0] drop_cnt;

  funprof_ctrl #(.DEPTH(D), .TS_W(TW), .DROP_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .call       (call),
    .ret        (ret),
    .call_target(call_target),
    .rec_valid  (rec_valid),
    .rec_ready  (rec_ready),
    .rec_addr   (rec_addr),
    .rec_cycles (rec_cycles),
    .rec_depth  (rec_depth),
    .rec_trunc  (rec_trunc),
    .busy       (busy),
    .ovf        (ovf),
    .unf        (unf),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: stack as a queue, holding register as a single optional record.
  typedef struct {
    logic [31:0]   addr;
    logic [TW-1:0] ts;
    logic [TW-1:0] child;
  } ent_t;

  ent_t          stk[$];
  bit            m_run, m_flush, m_hv, m_trunc, m_ovf, m_unf;
  logic [31:0]   m_addr;
  logic [TW-1:0] m_cyc, m_ts;
  int            m_depth, m_shadow, m_drop;

  task automatic m_reset();
    stk.delete();
    m_run = 0; m_flush = 0; m_hv = 0; m_trunc = 0; m_ovf = 0; m_unf = 0;
    m_addr = '0; m_cyc = '0; m_ts = '0; m_depth = 0; m_shadow = 0; m_drop = 0;
  endtask

  task automatic m_pop(input bit trunc, input bit free);
    ent_t e, t;
    int depth;
    logic [TW-1:0] incl;
    depth = stk.size();
    e = stk.pop_back();
    incl = m_ts - e.ts;
    if (stk.size() > 0) begin
      t = stk[stk.size()-1];
      t.child = t.child + incl;
      stk[stk.size()-1] = t;
    end
    if (free) begin
      m_hv = 1; m_addr = e.addr; m_depth = depth; m_trunc = trunc;
      m_cyc = Excl ? incl - e.child : incl;
    end else if (m_drop < (1 << DW) - 1) begin
      m_drop++;
    end
  endtask

  task automatic m_step(input bit en, input bit c, input bit r, input logic [31:0] tgt,
                        input bit rdy);
    bit free;
    ent_t e;
    free = !m_hv || rdy;
    if (m_hv && rdy) m_hv = 0;
    if (!m_run && !m_flush) begin
      if (en) begin
        m_run = 1; m_ts = '0; stk.delete(); m_shadow = 0; m_ovf = 0; m_unf = 0; m_drop = 0;
      end
    end else if (m_run) begin
      if (r) begin
        if (m_shadow > 0)        m_shadow--;
        else if (stk.size() > 0) m_pop(1'b0, free);
        else                     m_unf = 1;
      end
      if (c) begin
        if (stk.size() < D) begin
          e.addr = tgt; e.ts = m_ts; e.child = '0;
          stk.push_back(e);
        end else begin
          m_ovf = 1;
          if (m_shadow < (1 << TW) - 1) m_shadow++;
        end
      end
      if (!en) begin m_run = 0; m_flush = 1; m_shadow = 0; end
      m_ts++;
    end else begin
      if (stk.size() > 0) begin
        if (free) m_pop(1'b1, 1'b1);
      end else if (free) begin
        m_flush = 0;
      end
      m_ts++;
    end
  endtask

  task automatic check_outputs();
    check_eq("valid", rec_valid, m_hv);
    check_eq("busy", busy, m_run || m_flush);
    check_eq("ovf", ovf, m_ovf);
    check_eq("unf", unf, m_unf);
    check_eq("drop", drop_cnt, m_drop);
    if (m_hv) begin
      check_eq("addr", rec_addr, m_addr);
      check_eq("cycles", rec_cycles, m_cyc);
      check_eq("depth", rec_depth, m_depth);
      check_eq("trunc", rec_trunc, m_trunc);
    end
  endtask

  // Called at a falling edge: check, drive, advance model, wait one clock.
  task automatic cycle(input bit en, input bit c, input bit r, input logic [31:0] tgt,
                       input bit rdy);
    check_outputs();
    enable = en; call = c; ret = r; call_target = tgt; rec_ready = rdy;
    m_step(en, c, r, tgt, rdy);
    @(negedge clk);
  endtask

  task automatic idle_run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic drain_to_idle();
    for (int i = 0; i < 60 && (m_run || m_flush || m_hv); i++)
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  bit cur_en;

  initial begin
    rst_n = 1'b0; enable = 1'b0; call = 1'b0; ret = 1'b0; call_target = '0; rec_ready = 1'b0;
    m_reset();
    #2;
    check_outputs();
    check_eq("rst_depth", rec_depth, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single call/ret
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0000_1000, 1'b1);
    idle_run(9);
    cycle(1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
    check_eq("single_valid", rec_valid, 1);
    check_eq("single_addr", rec_addr, 32'h0000_1000);
    check_eq("single_cyc", rec_cycles, 10);
    check_eq("single_depth", rec_depth, 1);
    check_eq("single_trunc", rec_trunc, 0);

    // Nesting
    cycle(1'b1, 1'b1, 1'b0, 32'h0000_a000, 1'b1);
    idle_run(2);
    cycle(1'b1, 1'b1, 1'b0, 32'h0000_b000, 1'b1);
    idle_run(4);
    cycle(1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
    check_eq("nest_b_cyc", rec_cycles, 5);
    check_eq("nest_b_depth", rec_depth, 2);
    idle_run(11);
    cycle(1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
    check_eq("nest_a_cyc", rec_cycles, Excl ? 15 : 20);
    check_eq("nest_a_depth", rec_depth, 1);

    // Overflow
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'h100 + i, 1'b1);
    check_eq("ovf_set", ovf, 1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
    check_eq("ovf_last_depth", rec_depth, 1);
    check_eq("ovf_unf", unf, 0);
    idle_run(2);

    // Backpressure drop
    cycle(1'b1, 1'b1, 1'b0, 32'h200, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h300, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    check_eq("bp_drop", drop_cnt, 1);
    check_eq("bp_held", rec_addr, 32'h300);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("bp_after", rec_valid, 0);

    // Underflow then flush
    cycle(1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
    check_eq("unf_set", unf, 1);
    check_eq("unf_norec", rec_valid, 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h400 + i, 1'b1);
    for (int i = 0; i < 40 && (m_run || m_flush); i++)
      cycle(1'b0, 1'b0, 1'b0, 32'h0, i[0] == 1'b0);
    check_eq("flush_busy", busy, 0);
    check_eq("flush_drop", drop_cnt, 1);

    // Timestamp wrap
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 300 && m_ts != 8'd253; i++) idle_run(1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0000_5000, 1'b1);
    idle_run(5);
    cycle(1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
    check_eq("wrap_cyc", rec_cycles, 6);

    // Drop counter saturation
    idle_run(1);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h600 + i, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    end
    check_eq("drop_sat", drop_cnt, 15);
    drain_to_idle();

    // Asynchronous reset mid-run
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h700, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h701, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    m_reset();
    check_outputs();
    check_eq("arst_busy", busy, 0);
    #1;
    rst_n = 1'b1;

    // Random traffic
    cur_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) cur_en = ~cur_en;
      cycle(cur_en, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom,
            $urandom_range(0, 3) != 0);
    end
    drain_to_idle();
    check_outputs();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
